// File: rtl/irq_ctl.sv
// Multi-source interrupt controller: edge/level pending capture, mask, lowest-index priority, one outstanding irq.
// Pending bits set one cycle after the source edge and irq follows a cycle later; pause freezes the state machine and outputs.
module irq_ctl #(
  parameter int                NSRC      = 8,
  parameter int                VEC_W     = 3,
  parameter logic [NSRC-1:0]   EDGE_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   src_irq,
  input  logic              mask_we,
  input  logic [NSRC-1:0]   mask_din,
  output logic [NSRC-1:0]   mask_q,
  input  logic              clr_we,
  input  logic [NSRC-1:0]   clr_din,
  output logic [NSRC-1:0]   pend_q,
  input  logic              pause,
  output logic              irq,
  input  logic              iack,
  output logic [VEC_W-1:0]  vec,
  output logic              in_service
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

  logic [1:0]       state;
  logic [NSRC-1:0]  src_prev;
  logic             iack_prev;
  logic [NSRC-1:0]  active;
  logic [NSRC-1:0]  pend_n;
  logic [VEC_W-1:0] winner;
  logic             accept;
  logic             iack_fall;

  assign active    = pend_q & mask_q;
  assign accept    = (state == ST_REQ) && !pause && iack && !iack_prev;
  assign iack_fall = !iack && iack_prev;

  // Descending scan so the lowest set index is the last assignment and wins.
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) winner = VEC_W'(i);
    end
  end

  always_comb begin
    pend_n = pend_q;
    for (int i = 0; i < NSRC; i++) begin
      if (EDGE_MASK[i]) begin
        if (src_irq[i] && !src_prev[i])
          pend_n[i] = 1'b1;
        else if ((clr_we && clr_din[i]) || (accept && (vec == VEC_W'(i))))
          pend_n[i] = 1'b0;
      end else begin
        pend_n[i] = src_irq[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q    <= '0;
      mask_q    <= '0;
      src_prev  <= '0;
      iack_prev <= 1'b0;
    end else begin
      pend_q    <= pend_n;
      src_prev  <= src_irq;
      iack_prev <= iack;
      if (mask_we) mask_q <= mask_din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      irq        <= 1'b0;
      vec        <= '0;
      in_service <= 1'b0;
    end else if (!pause) begin
      case (state)
        ST_IDLE: begin
          if (active != '0) begin
            state <= ST_REQ;
            irq   <= 1'b1;
            vec   <= winner;
          end
        end
        ST_REQ: begin
          if (accept) begin
            state      <= ST_SERV;
            irq        <= 1'b0;
            in_service <= 1'b1;
          end else if (active == '0) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
          end else begin
            vec <= winner;
          end
        end
        ST_SERV: begin
          // No nesting: pending bits keep accumulating but are not looked at here.
          if (iack_fall) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          irq        <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: cycle-level reference model compared every cycle, plus directed literal checks.
module tb_irq_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src_irq, mask_din, clr_din;
  logic       mask_we, clr_we, pause, iack;
  logic [7:0] mask_q, pend_q;
  logic       irq, in_service;
  logic [2:0] vec;

  int n_checks = 0;
  int n_pass   = 0;

  irq_ctl #(.NSRC(8), .VEC_W(3), .EDGE_MASK(8'h04)) dut (
    .clk(clk), .rst(rst_n), .src_irq(src_irq),
    .mask_we(mask_we), .mask_din(mask_din), .mask_q(mask_q),
    .clr_we(clr_we), .clr_din(clr_din), .pend_q(pend_q),
    .pause(pause), .irq(irq), .iack(iack), .vec(vec), .in_service(in_service)
  );

  always #5 clk = ~clk;

  // Reference model: "requesting" is just irq high, "servicing" is in_service high.
  bit       m_pend[8];
  bit [7:0] m_mask;
  bit [7:0] m_src_prev;
  bit       m_iack_prev;
  bit       m_irq, m_serv;
  int       m_vec;

  function automatic int lowest_active();
    for (int i = 0; i < 8; i++) if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_mask = 0; m_src_prev = 0; m_iack_prev = 0;
      m_irq = 0; m_serv = 0; m_vec = 0;
    end else begin
      int  w;
      bit  acc;
      w   = lowest_active();
      acc = m_irq && !pause && iack && !m_iack_prev;
      for (int i = 0; i < 8; i++) begin
        if (i == 2) begin
          if (src_irq[i] && !m_src_prev[i]) m_pend[i] = 1;
          else if ((clr_we && clr_din[i]) || (acc && m_vec == i)) m_pend[i] = 0;
        end else begin
          m_pend[i] = src_irq[i];
        end
      end
      if (!pause) begin
        if (m_serv) begin
          if (!iack && m_iack_prev) m_serv = 0;
        end else if (m_irq) begin
          if (acc) begin m_irq = 0; m_serv = 1; end
          else if (w < 0) m_irq = 0;
          else m_vec = w;
        end else if (w >= 0) begin
          m_irq = 1; m_vec = w;
        end
      end
      if (mask_we) m_mask = mask_din;
      m_src_prev  = src_irq;
      m_iack_prev = iack;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int model_pend();
    int p = 0;
    for (int i = 0; i < 8; i++) if (m_pend[i]) p |= (1 << i);
    return p;
  endfunction

  always @(negedge clk) begin
    check("model irq", int'(irq), int'(m_irq));
    check("model in_service", int'(in_service), int'(m_serv));
    check("model vec", int'(vec), m_vec);
    check("model mask_q", int'(mask_q), int'(m_mask));
    check("model pend_q", int'(pend_q), model_pend());
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; src_irq = 0; mask_din = 0; clr_din = 0;
    mask_we = 0; clr_we = 0; pause = 0; iack = 0;
    #3;
    check("reset irq", irq, 0);
    check("reset vec", vec, 0);
    check("reset in_service", in_service, 0);
    check("reset mask", mask_q, 0);
    check("reset pend", pend_q, 0);
    tick();
    rst_n = 1;

    // Edge source 2: pulse, request, accept, return.
    mask_we = 1; mask_din = 8'h04; tick();
    mask_we = 0; src_irq = 8'h04; tick();
    check("t1 pend after edge", pend_q, 8'h04);
    check("t1 irq not yet", irq, 0);
    src_irq = 0; tick();
    check("t1 irq", irq, 1);
    check("t1 vec", vec, 2);
    iack = 1; tick();
    check("t1 accept irq", irq, 0);
    check("t1 accept in_service", in_service, 1);
    check("t1 accept pend cleared", pend_q, 0);
    tick();
    iack = 0; tick();
    check("t1 return in_service", in_service, 0);
    tick();
    check("t1 idle irq", irq, 0);

    // Level sources 5 and 1 together: 1 wins, then 5.
    mask_we = 1; mask_din = 8'hFF; src_irq = 8'h22; tick();
    mask_we = 0; tick();
    check("t2 irq", irq, 1);
    check("t2 vec", vec, 1);
    iack = 1; tick();
    check("t2 in_service", in_service, 1);
    src_irq = 8'h20; iack = 0; tick();
    check("t2 return", in_service, 0);
    tick();
    check("t2 second irq", irq, 1);
    check("t2 second vec", vec, 5);

    // Higher priority level source 0 overrides before acceptance, then vec freezes.
    src_irq = 8'h21; tick();
    check("t3 vec unchanged yet", vec, 5);
    tick();
    check("t3 vec override", vec, 0);
    iack = 1; tick();
    check("t3 in_service", in_service, 1);
    src_irq = 8'h20; tick();
    check("t3 vec frozen", vec, 0);
    check("t3 still serving", in_service, 1);
    iack = 0; src_irq = 0; tick();
    tick();
    check("t3 idle irq", irq, 0);
    check("t3 idle in_service", in_service, 0);

    // Level source 3 withdrawn before acceptance.
    src_irq = 8'h08; tick();
    tick();
    check("t4 irq", irq, 1);
    check("t4 vec", vec, 3);
    src_irq = 0; tick();
    tick();
    check("t4 withdrawn irq", irq, 0);
    check("t4 withdrawn in_service", in_service, 0);

    // Set beats clear on the same edge; pause holds irq low.
    src_irq = 8'h04; clr_we = 1; clr_din = 8'h04; pause = 1; tick();
    check("t5 set wins", pend_q, 8'h04);
    clr_we = 0; clr_din = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5 paused irq", irq, 0);
    end
    pause = 0; tick();
    check("t5 irq after pause", irq, 1);
    check("t5 vec after pause", vec, 2);
    iack = 1; tick();
    check("t5 accept pend cleared", pend_q, 0);
    check("t5 in_service", in_service, 1);

    // Asynchronous reset in the middle of service.
    #2 rst_n = 0;
    #1;
    check("t6 async irq", irq, 0);
    check("t6 async in_service", in_service, 0);
    check("t6 async vec", vec, 0);
    check("t6 async mask", mask_q, 0);
    check("t6 async pend", pend_q, 0);
    iack = 0; src_irq = 0;
    tick();
    rst_n = 1;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_ctl.md
Name: irq_ctl

Overview:
- Multi-source interrupt controller that feeds the single irq/iack pair of the pipeline control FSM.
- Captures up to NSRC interrupt sources as edge- or level-triggered pending bits and applies a software mask.
- Picks the highest-priority enabled source, raises irq, and holds a stable vector while the core is in service.
- Sequences the request / accept / in-service / return handshake, so only one interrupt is outstanding at a time.

Parameters:
- NSRC, 8, number of interrupt sources (2..16).
- VEC_W, 3, vector width; must equal ceil(log2(NSRC)).
- EDGE_MASK, 8'h00, per source: 1 = rising-edge triggered, 0 = level triggered.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- src_irq  in  NSRC  raw source requests, synchronous to clk.
- mask_we  in  1  write enable for mask register.
- mask_din  in  NSRC  new mask value (1 = enabled).
- mask_q  out  NSRC  current mask register.
- clr_we  in  1  write-1-to-clear strobe for pending bits.
- clr_din  in  NSRC  pending bits to clear (affects edge sources only).
- pend_q  out  NSRC  raw pending bits, unmasked.
- pause  in  1  pipeline stall; freezes the state machine.
- irq  out  1  interrupt request to the control FSM.
- iack  in  1  level acknowledge from the control FSM: rises on IRQ entry, falls on RET.
- vec  out  VEC_W  index of the selected / in-service source.
- in_service  out  1  high while an interrupt is being serviced.

Behaviour:
- Reset (rst=0, async): state IDLE; irq=0, vec=0, in_service=0, mask_q=0, pend_q=0; src and iack history registers = 0.
- Pending capture, every cycle, independent of pause and state:
  - Edge source i: pend[i] is set on src_irq[i] & ~src_prev[i].
  - Edge source i: pend[i] is cleared by clr_we&clr_din[i], or by acceptance of source i.
  - Edge source i, simultaneous set and clear: set wins.
  - Level source i: pend[i] <= src_irq[i]. clr and acceptance have no effect.
- Mask: mask_q <= mask_din on mask_we. Masked sources still record pending bits but never request.
- Priority: active = pend_q & mask_q. The lowest set index wins, via a combinational priority encoder.
- State machine (registered). Transitions are taken only when pause=0; pause=1 holds state and all outputs.
  - IDLE: if active != 0, go to REQ; irq<=1, vec<=winner.
  - REQ, acceptance (iack=1 and iack_prev=0):
    - go to SERV; irq<=0, in_service<=1; vec frozen.
    - clear pend[vec] if vec is an edge source.
  - REQ, no acceptance, active == 0 (withdrawn or masked): go to IDLE; irq<=0; vec holds its last value.
  - REQ, otherwise: vec<=winner each cycle, so a higher-priority arrival overrides until acceptance.
  - SERV: on iack falling (iack=0 and iack_prev=1), go to IDLE; in_service<=0. A new request is possible on the next cycle.
  - SERV: new pending bits accumulate but produce no irq (no nesting).
- iack_prev updates every cycle regardless of pause. An iack edge that occurs during pause is therefore lost; the control FSM does not toggle iack while stalled.
- Latency:
  - src edge before clock edge k: pend set after edge k, irq high after edge k+1.
  - iack rise sampled at edge m: irq low and in_service high after edge m.
- iack high while in IDLE is ignored, with no state change.
- An unused vec is don't-care only in the sense of holding its last value; it never goes X.

Test Plan:
- Reset, then mask=8'h04, EDGE_MASK=8'h04, pulse src[2] for 1 cycle -> pend_q=8'h04 next cycle, irq=1 and vec=2 one cycle later; raise iack -> irq=0, in_service=1, pend_q=0; drop iack -> in_service=0, state IDLE.
- mask=8'hFF, level src[5] and src[1] high together -> vec=1; after acceptance and return, with src[1] low -> vec=5 requested.
- In REQ with vec=5, assert src[0] (level) -> vec changes to 0 before iack; iack rise -> vec frozen at 0 through SERV even if src[0] drops.
- Level src[3] high, irq asserted, src[3] drops before iack -> return to IDLE, irq=0, no in_service.
- Edge src[2] rises in the same cycle as clr_we with clr_din=8'h04 -> pend[2]=1. pause=1 held for 4 cycles with pending active -> irq stays 0 until pause=0.
- Assert rst mid-SERV -> all outputs 0 immediately (asynchronous), mask cleared.
